reg_writeback_ctrl: RTL and testbench

Write-side controller for the integer register file: merges writeback results from the ALU (single-cycle) and the load unit (variable latency) into the register file's single write port (rd, data_write, write_en). Loads are buffered in a small FIFO, the ALU has priority with a bounded starvation guard, and per-register pending flags are exported to decode for read-after-write hazard detection. Sits between execute/memory stages and the register file.

---
 rtl/reg_writeback_ctrl_pkg.sv | 35 +++
 rtl/reg_writeback_ctrl_fifo.sv | 98 +++++++++
 rtl/reg_writeback_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_pkg
// Purpose  : Shared types for the register-file writeback controller:
//            the writeback request record, the write-port grant encoding
//            and the default data/index widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reg_wb_pkg;

  localparam int c_reg_data_width_pow = 6;
  localparam int c_reg_data_width     = 1 << c_reg_data_width_pow;
  localparam int c_reg_mem_depth_pow  = 5;

  // One pending register-file write: destination index plus result data.
  typedef struct packed {
    logic [c_reg_mem_depth_pow-1:0] rd;
    logic [c_reg_data_width-1:0]    data;
  } wb_req_t;

  // Owner of the single register-file write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_t;

  // x0 is hard-wired to zero, so a write aimed at it is never a real write.
  function automatic logic is_live_rd(input logic [c_reg_mem_depth_pow-1:0] rd);
    return rd != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO of writeback requests for the load path.
//            Every slot's destination index and valid bit are exported so
//            the controller can report read-after-write hazards on data
//            that is still buffered.
// Ports    : clk_in, reset        - clock / synchronous active-high reset
//            push_in, push_req_in - enqueue strobe and request
//            pop_in               - dequeue strobe (head is consumed)
//            head_req_out         - request at the head of the queue
//            full_out, empty_out  - occupancy flags
//            count_out            - occupancy, 0..depth
//            entry_rd_out         - destination index held in each slot
//            entry_valid_out      - slot holds a live request
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH_POW = 1  // depth = 1 << DEPTH_POW, DEPTH_POW >= 1
) (
  input  logic                                               clk_in,
  input  logic                                               reset,
  input  logic                                               push_in,
  input  wb_req_t                                            push_req_in,
  input  logic                                               pop_in,
  output wb_req_t                                            head_req_out,
  output logic                                               full_out,
  output logic                                               empty_out,
  output logic [DEPTH_POW:0]                                 count_out,
  output logic [(1<<DEPTH_POW)-1:0][c_reg_mem_depth_pow-1:0] entry_rd_out,
  output logic [(1<<DEPTH_POW)-1:0]                          entry_valid_out
);

  localparam int                   c_depth_n = 1 << DEPTH_POW;
  localparam logic [DEPTH_POW:0]   c_full    = (DEPTH_POW+1)'(c_depth_n);
  localparam logic [DEPTH_POW:0]   c_cnt_one = (DEPTH_POW+1)'(1);
  localparam logic [DEPTH_POW-1:0] c_ptr_one = DEPTH_POW'(1);

  wb_req_t                r_mem [0:c_depth_n-1];
  logic [c_depth_n-1:0]   r_valid;
  logic [DEPTH_POW-1:0]   r_wr_ptr;
  logic [DEPTH_POW-1:0]   r_rd_ptr;
  logic [DEPTH_POW:0]     r_count;

  logic w_push;
  logic w_pop;

  // Pointers wrap naturally because the depth is a power of two; the
  // separate count is what tells full from empty when they coincide.
  assign full_out  = (r_count == c_full);
  assign empty_out = (r_count == '0);
  assign w_push    = push_in && !full_out;
  assign w_pop     = pop_in && !empty_out;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      // A push and a pop never address the same slot: that would need the
      // FIFO to be both empty (pop blocked) and full (push blocked).
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: slots are only read while valid.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_req_in;
    end
  end

  assign head_req_out    = r_mem[r_rd_ptr];
  assign count_out       = r_count;
  assign entry_valid_out = r_valid;

  for (genvar g = 0; g < c_depth_n; g++) begin : g_entry_rd
    assign entry_rd_out[g] = r_mem[g].rd;
  end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_ctrl
// Purpose  : Arbitrates the register file's single write port between the
//            single-cycle ALU and the variable-latency load unit. Loads are
//            buffered; the ALU wins by default but a starvation guard forces
//            a load through after STARVE_LIMIT consecutive ALU wins. Pending
//            flags for two decode source indices flag RAW hazards against
//            buffered loads and the write currently being presented.
// Ports    : clk_in, reset                      - clock / sync active-high reset
//            alu_valid_in/ready_out/rd_in/data_in - ALU result handshake
//            ld_valid_in/ready_out/rd_in/data_in  - load result handshake
//            rd_out, data_write_out, write_en_out - register file write port
//            query_rs1_in, query_rs2_in           - decode source indices
//            rs1_pending_out, rs2_pending_out     - uncommitted write to source
//            ld_count_out                         - load FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_ctrl
  import reg_wb_pkg::*;
#(
  parameter int REG_DATA_WIDTH_POW = c_reg_data_width_pow,
  parameter int REG_MEM_DEPTH_POW  = c_reg_mem_depth_pow,
  parameter int LD_FIFO_DEPTH_POW  = 1,
  parameter int STARVE_LIMIT       = 4
) (
  input  logic                                clk_in,
  input  logic                                reset,
  input  logic                                alu_valid_in,
  output logic                                alu_ready_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]        alu_rd_in,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  alu_data_in,
  input  logic                                ld_valid_in,
  output logic                                ld_ready_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]        ld_rd_in,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  ld_data_in,
  output logic [REG_MEM_DEPTH_POW-1:0]        rd_out,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  data_write_out,
  output logic                                write_en_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]        query_rs1_in,
  input  logic [REG_MEM_DEPTH_POW-1:0]        query_rs2_in,
  output logic                                rs1_pending_out,
  output logic                                rs2_pending_out,
  output logic [LD_FIFO_DEPTH_POW:0]          ld_count_out
);

  localparam int                    c_depth     = 1 << LD_FIFO_DEPTH_POW;
  localparam int                    c_starve_w  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
  localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);

  wb_req_t                                    w_alu_req;
  wb_req_t                                    w_ld_req;
  wb_req_t                                    w_head_req;
  wb_req_t                                    w_grant_req;
  grant_t                                     w_grant;
  logic                                       w_fifo_full;
  logic                                       w_fifo_empty;
  logic                                       w_forced_ld;
  logic                                       w_ld_push;
  logic                                       w_ld_pop;
  logic [LD_FIFO_DEPTH_POW:0]                 w_ld_count;
  logic [c_depth-1:0][REG_MEM_DEPTH_POW-1:0]  w_entry_rd;
  logic [c_depth-1:0]                         w_entry_valid;

  logic [c_starve_w-1:0]                      r_starve_cnt;
  logic                                       r_we;
  logic [REG_MEM_DEPTH_POW-1:0]               r_rd;
  logic [(1<<REG_DATA_WIDTH_POW)-1:0]         r_data;

  assign w_alu_req.rd   = alu_rd_in;
  assign w_alu_req.data = alu_data_in;
  assign w_ld_req.rd    = ld_rd_in;
  assign w_ld_req.data  = ld_data_in;

  // ---------------------------------------------------------------------------
  // Load buffer. Ready comes from registered occupancy only, so a load that
  // arrives while the FIFO is full waits even if the head drains this cycle.
  // ---------------------------------------------------------------------------
  assign ld_ready_out = !reset && !w_fifo_full;
  assign w_ld_push    = ld_valid_in && ld_ready_out;
  assign w_ld_pop     = (w_grant == GNT_LD);

  wb_fifo #(
    .DEPTH_POW (LD_FIFO_DEPTH_POW)
  ) u_ld_fifo (
    .clk_in          (clk_in),
    .reset           (reset),
    .push_in         (w_ld_push),
    .push_req_in     (w_ld_req),
    .pop_in          (w_ld_pop),
    .head_req_out    (w_head_req),
    .full_out        (w_fifo_full),
    .empty_out       (w_fifo_empty),
    .count_out       (w_ld_count),
    .entry_rd_out    (w_entry_rd),
    .entry_valid_out (w_entry_valid)
  );

  assign ld_count_out = w_ld_count;

  // ---------------------------------------------------------------------------
  // Arbitration: forced load > ALU > buffered load.
  // ---------------------------------------------------------------------------
  assign w_forced_ld   = (r_starve_cnt == c_starve_max) && !w_fifo_empty;
  assign alu_ready_out = !reset && !w_forced_ld;

  always_comb begin
    w_grant = GNT_NONE;
    if (reset) begin
      w_grant = GNT_NONE;
    end else if (w_forced_ld) begin
      w_grant = GNT_LD;
    end else if (alu_valid_in) begin
      w_grant = GNT_ALU;
    end else if (!w_fifo_empty) begin
      w_grant = GNT_LD;
    end
  end

  always_comb begin
    w_grant_req = w_alu_req;
    if (w_grant == GNT_LD) begin
      w_grant_req = w_head_req;
    end
  end

  // Counts ALU wins only while a load is actually waiting.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_ld_pop || w_fifo_empty) begin
      r_starve_cnt <= '0;
    end else if ((w_grant == GNT_ALU) && (r_starve_cnt != c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + c_starve_one;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage. Address/data hold when idle; only the enable drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (w_grant != GNT_NONE) begin
      r_we   <= is_live_rd(w_grant_req.rd);
      r_rd   <= w_grant_req.rd;
      r_data <= w_grant_req.data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign write_en_out   = r_we;
  assign rd_out         = r_rd;
  assign data_write_out = r_data;

  // ---------------------------------------------------------------------------
  // Hazard lookup: buffered loads plus the write on the port right now. An
  // ALU request still on its inputs is deliberately not reported; decode
  // covers that case through its own forwarding.
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_pending_out = 1'b0;
    rs2_pending_out = 1'b0;
    for (int i = 0; i < c_depth; i++) begin
      if (w_entry_valid[i] && (w_entry_rd[i] == query_rs1_in)) begin
        rs1_pending_out = 1'b1;
      end
      if (w_entry_valid[i] && (w_entry_rd[i] == query_rs2_in)) begin
        rs2_pending_out = 1'b1;
      end
    end
    if (r_we && (r_rd == query_rs1_in)) begin
      rs1_pending_out = 1'b1;
    end
    if (r_we && (r_rd == query_rs2_in)) begin
      rs2_pending_out = 1'b1;
    end
    if (query_rs1_in == '0) begin
      rs1_pending_out = 1'b0;
    end
    if (query_rs2_in == '0) begin
      rs2_pending_out = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_ctrl
// Purpose  : Self-checking bench for reg_writeback_ctrl. A queue-based
//            reference model predicts handshakes, occupancy, hazard flags
//            and the sequence of register-file writes; a monitor compares
//            every presented write against the expected-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_ctrl;

  localparam int LIMIT = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        alu_valid_in = 1'b0;
  logic        alu_ready_out;
  logic [4:0]  alu_rd_in = '0;
  logic [63:0] alu_data_in = '0;
  logic        ld_valid_in = 1'b0;
  logic        ld_ready_out;
  logic [4:0]  ld_rd_in = '0;
  logic [63:0] ld_data_in = '0;
  logic [4:0]  rd_out;
  logic [63:0] data_write_out;
  logic        write_en_out;
  logic [4:0]  query_rs1_in = '0;
  logic [4:0]  query_rs2_in = '0;
  logic        rs1_pending_out;
  logic        rs2_pending_out;
  logic [1:0]  ld_count_out;

  reg_writeback_ctrl #(
    .REG_DATA_WIDTH_POW (6),
    .REG_MEM_DEPTH_POW  (5),
    .LD_FIFO_DEPTH_POW  (1),
    .STARVE_LIMIT       (LIMIT)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .alu_valid_in    (alu_valid_in),
    .alu_ready_out   (alu_ready_out),
    .alu_rd_in       (alu_rd_in),
    .alu_data_in     (alu_data_in),
    .ld_valid_in     (ld_valid_in),
    .ld_ready_out    (ld_ready_out),
    .ld_rd_in        (ld_rd_in),
    .ld_data_in      (ld_data_in),
    .rd_out          (rd_out),
    .data_write_out  (data_write_out),
    .write_en_out    (write_en_out),
    .query_rs1_in    (query_rs1_in),
    .query_rs2_in    (query_rs2_in),
    .rs1_pending_out (rs1_pending_out),
    .rs2_pending_out (rs2_pending_out),
    .ld_count_out    (ld_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model state
  req_t        m_fifo[$];   // loads held inside the controller
  req_t        prod_q[$];   // loads the producer still has to hand over
  exp_t        sb[$];       // writes expected on the register-file port
  int          m_starve = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0;
  bit          m_known = 1'b0;
  bit          m_arm = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit exp_pending(input logic [4:0] q);
    bit hit = 1'b0;
    if (q == 5'd0) return 1'b0;
    foreach (m_fifo[i]) if (m_fifo[i].rd == q) hit = 1'b1;
    if (m_we && m_rd == q) hit = 1'b1;
    return hit;
  endfunction

  // One clock cycle: drive, check combinational/registered outputs against
  // the model, then advance the model across the coming edge.
  task automatic step(input bit rst, input bit av, input logic [4:0] ard,
                      input logic [63:0] adat, input logic [4:0] q1, input logic [4:0] q2);
    int   sz;
    bit   forced, push;
    int   g;
    req_t req;
    exp_t e;
    @(posedge clk_in);
    #1;
    if (m_arm) m_known = 1'b1;
    reset        = rst;
    alu_valid_in = av;
    alu_rd_in    = ard;
    alu_data_in  = adat;
    query_rs1_in = q1;
    query_rs2_in = q2;
    if (prod_q.size() > 0) begin
      ld_valid_in = 1'b1;
      ld_rd_in    = prod_q[0].rd;
      ld_data_in  = prod_q[0].data;
    end else begin
      ld_valid_in = 1'b0;
      ld_rd_in    = 5'($urandom_range(0, 31));
      ld_data_in  = {$urandom, $urandom};
    end
    #3;
    sz     = m_fifo.size();
    forced = (m_starve == LIMIT) && (sz > 0);
    check("alu_ready", alu_ready_out, (!rst && !forced));
    check("ld_ready",  ld_ready_out,  (!rst && sz < DEPTH));
    if (m_known) begin
      check("ld_count",    ld_count_out,    sz);
      check("write_en",    write_en_out,    m_we);
      check("rd_out",      rd_out,          m_rd);
      check("data_write",  data_write_out,  m_data);
      check("rs1_pending", rs1_pending_out, exp_pending(q1));
      check("rs2_pending", rs2_pending_out, exp_pending(q2));
    end
    if (rst) begin
      m_fifo.delete();
      m_starve = 0;
      m_we     = 1'b0;
      m_rd     = '0;
      m_data   = '0;
      m_arm    = 1'b1;
    end else begin
      g    = forced ? 2 : (av ? 1 : (sz > 0 ? 2 : 0));
      push = ld_valid_in && (sz < DEPTH);
      req  = '0;
      if (g == 1) begin
        req.rd   = ard;
        req.data = adat;
      end else if (g == 2) begin
        req = m_fifo.pop_front();
      end
      if (g == 2 || sz == 0) m_starve = 0;
      else if (g == 1 && m_starve < LIMIT) m_starve++;
      if (push) m_fifo.push_back(prod_q.pop_front());
      if (g != 0) begin
        m_rd   = req.rd;
        m_data = req.data;
        m_we   = (req.rd != 5'd0);
        if (m_we) begin
          e.rd   = req.rd;
          e.data = req.data;
          e.cyc  = 32'(cyc + 1);
          sb.push_back(e);
        end
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic [4:0] q1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, q1, 5'd0);
  endtask

  task automatic add_load(input logic [4:0] rd, input logic [63:0] data);
    req_t r;
    r.rd   = rd;
    r.data = data;
    prod_q.push_back(r);
  endtask

  // Scoreboard monitor: every presented write must be the next expected one,
  // in the expected cycle.
  always @(negedge clk_in) begin
    exp_t e;
    if (m_known && write_en_out === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write @cycle %0d: got rd=%0d data=%0h expected no write",
                 cyc, rd_out, data_write_out);
      end else begin
        e = sb.pop_front();
        check("wr_rd",    rd_out,         e.rd);
        check("wr_data",  data_write_out, e.data);
        check("wr_cycle", 64'(cyc),       64'(e.cyc));
      end
    end
  end

  initial begin
    // Reset, then a single ALU write.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    step(1'b0, 1'b1, 5'd5, 64'hABCD, 5'd5, 5'd0);
    idle(2, 5'd5);

    // Single load through an empty FIFO, hazard tracked on x7.
    add_load(5'd7, 64'h1234);
    idle(5, 5'd7);

    // x0 destinations from both sources.
    step(1'b0, 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd5);
    add_load(5'd0, 64'h5555);
    idle(3, 5'd0);

    // Three back-to-back loads against a continuous ALU stream.
    add_load(5'd1, 64'h1111);
    add_load(5'd2, 64'h2222);
    add_load(5'd3, 64'h3333);
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b1, 5'(10 + i), {32'hA1, 32'(i)}, 5'd1, 5'd3);
    idle(4, 5'd2);

    // Simultaneous enqueue/dequeue with ALU idle.
    add_load(5'd4, 64'h4444);
    add_load(5'd5, 64'h5050);
    add_load(5'd6, 64'h6666);
    idle(6, 5'd5);

    // Reset while two loads are buffered.
    add_load(5'd8, 64'h8888);
    add_load(5'd9, 64'h9999);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(20 + i), 64'(i), 5'd8, 5'd9);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd8, 5'd9);
    idle(4, 5'd9);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (prod_q.size() < 3 && $urandom_range(0, 99) < 40)
        add_load(5'($urandom_range(0, 7)), {$urandom, $urandom});
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 60),
           5'($urandom_range(0, 7)),
           {$urandom, $urandom},
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end
    idle(12, 5'd0);

    @(posedge clk_in);
    #2;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
